// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment scan decoder.
//   SEG_HEX   : active-low segment pattern for each hex value, indexed by value
//               (bit0=a ... bit6=g).
//   SEG_BLANK : all segments off.
//   state_e   : per-dwell tracking states.
package sevenseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_e;

endpackage

// File: rtl/sevenseg_pattern_decode.sv
// Combinational decode of one active-low seven-segment pattern.
// Ports:
//   pattern  : segment lines, active-low, bit0=a ... bit6=g
//   value    : hex value when is_hex is set, otherwise 0
//   is_hex   : pattern exactly matches one of the 16 hex glyphs
//   is_blank : pattern is all segments off
module sevenseg_pattern_decode
  import sevenseg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       is_hex,
  output logic       is_blank
);

  always_comb begin
    value  = '0;
    is_hex = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (pattern == SEG_HEX[i]) begin
        value  = 4'(i);
        is_hex = 1'b1;
      end
    end
    is_blank = (pattern == SEG_BLANK);
  end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Reads back a time-multiplexed active-low seven-segment display bus and
// recovers the value shown on each digit once its pattern has settled.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   seg_n        : segment lines, active-low (bit0=a ... bit6=g)
//   an_n         : digit anodes, active-low, one-hot when a digit is driven
//   digits       : captured nibble per digit, digit i at [4i+3:4i]
//   digit_valid  : digit i last captured a legal hex glyph
//   digit_blank  : digit i last captured the all-off pattern
//   digit_err    : digit i was ever captured with an illegal pattern (sticky)
//   update       : one-cycle pulse on any capture
//   update_idx   : digit index of the capture flagged by update
//   frame_done   : one-cycle pulse once every digit has been captured
module sevenseg_scan_decoder
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic [6:0]                                     seg_n,
  input  logic [NUM_DIGITS-1:0]                          an_n,
  output logic [4*NUM_DIGITS-1:0]                        digits,
  output logic [NUM_DIGITS-1:0]                          digit_valid,
  output logic [NUM_DIGITS-1:0]                          digit_blank,
  output logic [NUM_DIGITS-1:0]                          digit_err,
  output logic                                           update,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] update_idx,
  output logic                                           frame_done
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // Input sample stage
  logic [6:0]            s_seg_q;
  logic [NUM_DIGITS-1:0] s_an_q;

  // Dwell tracking
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [6:0]            ref_seg_q, ref_seg_d;
  logic [NUM_DIGITS-1:0] ref_an_q, ref_an_d;

  // Capture outputs
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    update_q, update_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    frame_q, frame_d;

  logic                    sel_legal;
  logic [IDX_W-1:0]        sel_idx;
  logic                    same_pair;
  logic                    capture;
  logic [3:0]              dec_value;
  logic                    dec_is_hex;
  logic                    dec_is_blank;
  logic [NUM_DIGITS-1:0]   seen_next;

  sevenseg_pattern_decode u_decode (
    .pattern  (s_seg_q),
    .value    (dec_value),
    .is_hex   (dec_is_hex),
    .is_blank (dec_is_blank)
  );

  always_comb begin
    sel_legal = $onehot(~s_an_q);
    sel_idx   = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!s_an_q[i]) sel_idx = IDX_W'(i);
    end
    same_pair = (s_seg_q == ref_seg_q) && (s_an_q == ref_an_q);
  end

  // Any legal pair that differs from the reference (or arrives from IDLE)
  // restarts the dwell, whether we were settling or already holding.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ref_seg_d = ref_seg_q;
    ref_an_d  = ref_an_q;
    capture   = 1'b0;
    if (!sel_legal) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == IDLE || !same_pair) begin
      state_d   = SETTLE;
      cnt_d     = CNT_W'(1);
      ref_seg_d = s_seg_q;
      ref_an_d  = s_an_q;
    end else if (state_q == SETTLE) begin
      if (cnt_q >= CNT_W'(STABLE_CYCLES)) begin
        capture = 1'b1;
        state_d = HELD;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Frame completion clears seen in the same cycle, so the completing
  // capture is never carried into the next frame.
  always_comb begin
    digits_d  = digits_q;
    valid_d   = valid_q;
    blank_d   = blank_q;
    err_d     = err_q;
    seen_d    = seen_q;
    idx_d     = idx_q;
    update_d  = capture;
    frame_d   = 1'b0;
    seen_next = seen_q | (NUM_DIGITS'(1) << sel_idx);
    if (capture) begin
      idx_d = sel_idx;
      if (dec_is_hex) begin
        digits_d[{sel_idx, 2'b00} +: 4] = dec_value;
        valid_d[sel_idx] = 1'b1;
        blank_d[sel_idx] = 1'b0;
      end else if (dec_is_blank) begin
        valid_d[sel_idx] = 1'b0;
        blank_d[sel_idx] = 1'b1;
      end else begin
        valid_d[sel_idx] = 1'b0;
        blank_d[sel_idx] = 1'b0;
        err_d[sel_idx]   = 1'b1;
      end
      if (&seen_next) begin
        frame_d = 1'b1;
        seen_d  = '0;
      end else begin
        seen_d = seen_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_seg_q   <= '1;
      s_an_q    <= '1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      ref_seg_q <= '1;
      ref_an_q  <= '1;
      digits_q  <= '0;
      valid_q   <= '0;
      blank_q   <= '0;
      err_q     <= '0;
      seen_q    <= '0;
      update_q  <= 1'b0;
      idx_q     <= '0;
      frame_q   <= 1'b0;
    end else begin
      s_seg_q   <= seg_n;
      s_an_q    <= an_n;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ref_seg_q <= ref_seg_d;
      ref_an_q  <= ref_an_d;
      digits_q  <= digits_d;
      valid_q   <= valid_d;
      blank_q   <= blank_d;
      err_q     <= err_d;
      seen_q    <= seen_d;
      update_q  <= update_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign digit_blank = blank_q;
  assign digit_err   = err_q;
  assign update      = update_q;
  assign update_idx  = idx_q;
  assign frame_done  = frame_q;

endmodule
